// File: rtl/cvxif_offload_pkg.sv
// rtl/cvxif_offload_pkg.sv - FSM state encoding and constants for the offload unit
package cvxif_offload_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_COMMIT = 3'd2,
        ST_WAIT   = 3'd3,
        ST_DRAIN  = 3'd4
    } offload_state_e;

    // Privilege mode reported with every offloaded instruction (machine mode).
    localparam logic [1:0] OFFLOAD_MODE = 2'b11;

endpackage

// File: rtl/cvxif_pkg.sv
// rtl/cvxif_pkg.sv - CoreV-X-Interface bundle types shared by core and coprocessor
// Provides the request/response bundles exchanged over the eXtension interface:
//   cvxif_req_t  : core -> coprocessor (compressed, issue, commit, memory response, result ready)
//   cvxif_resp_t : coprocessor -> core (compressed, issue response, memory request, result)
package cvxif_pkg;

    localparam int unsigned X_NUM_RS    = 3;
    localparam int unsigned X_ID_WIDTH  = 2;
    localparam int unsigned X_RFR_WIDTH = 32;
    localparam int unsigned X_RFW_WIDTH = 32;
    localparam int unsigned X_MEM_WIDTH = 32;

    typedef struct packed {
        logic [15:0]           instr;
        logic [1:0]            mode;
        logic [X_ID_WIDTH-1:0] id;
    } x_compressed_req_t;

    typedef struct packed {
        logic [31:0] instr;
        logic        accept;
    } x_compressed_resp_t;

    typedef struct packed {
        logic [31:0]                          instr;
        logic [1:0]                           mode;
        logic [X_ID_WIDTH-1:0]                id;
        logic [X_NUM_RS-1:0][X_RFR_WIDTH-1:0] rs;
        logic [X_NUM_RS-1:0]                  rs_valid;
    } x_issue_req_t;

    typedef struct packed {
        logic accept;
        logic writeback;
        logic dualwrite;
        logic dualread;
        logic loadstore;
        logic exc;
    } x_issue_resp_t;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0] id;
        logic                  commit_kill;
    } x_commit_t;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0]  id;
        logic [31:0]            addr;
        logic [1:0]             mode;
        logic                   we;
        logic [2:0]             size;
        logic [X_MEM_WIDTH-1:0] wdata;
        logic                   last;
        logic                   spec;
    } x_mem_req_t;

    typedef struct packed {
        logic       exc;
        logic [5:0] exccode;
    } x_mem_resp_t;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0]  id;
        logic [X_MEM_WIDTH-1:0] rdata;
        logic                   err;
    } x_mem_result_t;

    typedef struct packed {
        logic [X_ID_WIDTH-1:0]  id;
        logic [X_RFW_WIDTH-1:0] data;
        logic [4:0]             rd;
        logic                   we;
        logic                   exc;
        logic [5:0]             exccode;
    } x_result_t;

    typedef struct packed {
        logic              x_compressed_valid;
        x_compressed_req_t x_compressed_req;
        logic              x_issue_valid;
        x_issue_req_t      x_issue_req;
        logic              x_commit_valid;
        x_commit_t         x_commit;
        logic              x_mem_ready;
        x_mem_resp_t       x_mem_resp;
        logic              x_mem_result_valid;
        x_mem_result_t     x_mem_result;
        logic              x_result_ready;
    } cvxif_req_t;

    typedef struct packed {
        logic               x_compressed_ready;
        x_compressed_resp_t x_compressed_resp;
        logic               x_issue_ready;
        x_issue_resp_t      x_issue_resp;
        logic               x_mem_valid;
        x_mem_req_t         x_mem_req;
        logic               x_result_valid;
        x_result_t          x_result;
    } cvxif_resp_t;

endpackage

// File: rtl/cvxif_offload_unit.sv
// rtl/cvxif_offload_unit.sv - core-side single-outstanding CV-X-IF initiator
// Ports:
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   instr_valid_i/instr_ready_o   offload candidate handshake from the issue stage
//   instr_i, rs_i, rs_valid_i     instruction word and rs1..rs3 operands
//   flush_i                       core squashes the in-flight instruction
//   result_*_o                    one-cycle registered writeback pulse
//   illegal_o, timeout_o          exception flags qualifying result_valid_o
//   cvxif_req_o, cvxif_resp_i     eXtension interface bundles
module cvxif_offload_unit
    import cvxif_pkg::*;
    import cvxif_offload_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              instr_valid_i,
    output logic              instr_ready_o,
    input  logic [31:0]       instr_i,
    input  logic [2:0][31:0]  rs_i,
    input  logic [2:0]        rs_valid_i,
    input  logic              flush_i,
    output logic              result_valid_o,
    output logic [31:0]       result_data_o,
    output logic [4:0]        result_rd_o,
    output logic              result_we_o,
    output logic              illegal_o,
    output logic              timeout_o,
    output cvxif_req_t        cvxif_req_o,
    input  cvxif_resp_t       cvxif_resp_i
);

    localparam int unsigned CntW = $clog2(TimeoutCycles);
    localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

    offload_state_e        state_q;
    logic [X_ID_WIDTH-1:0] id_q;
    logic [X_ID_WIDTH-1:0] id_iss_q;
    logic [31:0]           instr_q;
    logic [2:0][31:0]      rs_q;
    logic [2:0]            rs_valid_q;
    logic [4:0]            rd_q;
    logic                  wb_q;
    logic                  flush_pend_q;
    logic [CntW-1:0]       cnt_q;

    logic                  result_valid_q;
    logic [31:0]           result_data_q;
    logic [4:0]            result_rd_q;
    logic                  result_we_q;
    logic                  illegal_q;
    logic                  timeout_q;

    logic issue_hs;
    logic commit_kill;
    logic res_match;
    logic unused_resp;

    assign issue_hs    = (state_q == ST_ISSUE) && cvxif_resp_i.x_issue_ready;
    assign commit_kill = flush_i | flush_pend_q;
    assign res_match   = cvxif_resp_i.x_result_valid && (cvxif_resp_i.x_result.id == id_iss_q);

    // Compressed/memory response fields and result exception info are not consumed.
    assign unused_resp = ^cvxif_resp_i;

    // Ready is forced low while reset is asserted even though the state already reads IDLE.
    assign instr_ready_o = (state_q == ST_IDLE) && !rst_i;

    assign result_valid_o = result_valid_q;
    assign result_data_o  = result_data_q;
    assign result_rd_o    = result_rd_q;
    assign result_we_o    = result_we_q;
    assign illegal_o      = illegal_q;
    assign timeout_o      = timeout_q;

    always_comb begin
        cvxif_req_o                      = '0;
        cvxif_req_o.x_issue_valid        = (state_q == ST_ISSUE);
        cvxif_req_o.x_issue_req.instr    = instr_q;
        cvxif_req_o.x_issue_req.mode     = OFFLOAD_MODE;
        cvxif_req_o.x_issue_req.id       = id_q;
        cvxif_req_o.x_issue_req.rs       = rs_q;
        cvxif_req_o.x_issue_req.rs_valid = rs_valid_q;
        cvxif_req_o.x_commit_valid       = (state_q == ST_COMMIT);
        cvxif_req_o.x_commit.id          = id_iss_q;
        cvxif_req_o.x_commit.commit_kill = commit_kill;
        cvxif_req_o.x_result_ready       = (state_q == ST_WAIT) || (state_q == ST_DRAIN);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= ST_IDLE;
            id_q           <= '0;
            id_iss_q       <= '0;
            instr_q        <= '0;
            rs_q           <= '0;
            rs_valid_q     <= '0;
            rd_q           <= '0;
            wb_q           <= 1'b0;
            flush_pend_q   <= 1'b0;
            cnt_q          <= '0;
            result_valid_q <= 1'b0;
            result_data_q  <= '0;
            result_rd_q    <= '0;
            result_we_q    <= 1'b0;
            illegal_q      <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            // Result outputs are single-cycle pulses and read zero otherwise.
            result_valid_q <= 1'b0;
            result_data_q  <= '0;
            result_rd_q    <= '0;
            result_we_q    <= 1'b0;
            illegal_q      <= 1'b0;
            timeout_q      <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (instr_valid_i && !flush_i) begin
                        instr_q      <= instr_i;
                        rs_q         <= rs_i;
                        rs_valid_q   <= rs_valid_i;
                        rd_q         <= instr_i[11:7];
                        flush_pend_q <= 1'b0;
                        state_q      <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    // A flush cannot withdraw the issue request; remember it for the commit.
                    if (flush_i) begin
                        flush_pend_q <= 1'b1;
                    end
                    if (issue_hs) begin
                        id_iss_q <= id_q;
                        id_q     <= id_q + X_ID_WIDTH'(1);
                        if (cvxif_resp_i.x_issue_resp.accept) begin
                            wb_q    <= cvxif_resp_i.x_issue_resp.writeback;
                            state_q <= ST_COMMIT;
                        end else begin
                            result_valid_q <= 1'b1;
                            result_rd_q    <= rd_q;
                            illegal_q      <= 1'b1;
                            state_q        <= ST_IDLE;
                        end
                    end
                end

                ST_COMMIT: begin
                    flush_pend_q <= 1'b0;
                    if (commit_kill) begin
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q   <= '0;
                        state_q <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    cnt_q <= cnt_q + CntW'(1);
                    if (res_match) begin
                        // A result arriving together with a flush is consumed silently.
                        if (!flush_i) begin
                            result_valid_q <= 1'b1;
                            result_data_q  <= cvxif_resp_i.x_result.data;
                            result_rd_q    <= rd_q;
                            result_we_q    <= cvxif_resp_i.x_result.we & wb_q;
                        end
                        state_q <= ST_IDLE;
                    end else if (flush_i) begin
                        state_q <= (cnt_q == CntLast) ? ST_IDLE : ST_DRAIN;
                    end else if (cnt_q == CntLast) begin
                        result_valid_q <= 1'b1;
                        result_rd_q    <= rd_q;
                        timeout_q      <= 1'b1;
                        state_q        <= ST_IDLE;
                    end
                end

                ST_DRAIN: begin
                    // The timeout budget keeps running from WAIT so a lost result cannot hang us.
                    cnt_q <= cnt_q + CntW'(1);
                    if (res_match || (cnt_q == CntLast)) begin
                        state_q <= ST_IDLE;
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cvxif_offload_unit.sv
// tb/tb_cvxif_offload_unit.sv - scoreboard bench for cvxif_offload_unit
module tb_cvxif_offload_unit;
    import cvxif_pkg::*;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we;
        logic        illegal;
        logic        timeout;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             instr_valid_i;
    logic             instr_ready_o;
    logic [31:0]      instr_i;
    logic [2:0][31:0] rs_i;
    logic [2:0]       rs_valid_i;
    logic             flush_i;
    logic             result_valid_o;
    logic [31:0]      result_data_o;
    logic [4:0]       result_rd_o;
    logic             result_we_o;
    logic             illegal_o;
    logic             timeout_o;
    cvxif_req_t       req;
    cvxif_resp_t      resp;

    int checks   = 0;
    int failures = 0;
    exp_t sb[$];
    exp_t m_e;
    logic [X_ID_WIDTH-1:0] exp_id;

    cvxif_offload_unit #(.TimeoutCycles(8)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .instr_valid_i  (instr_valid_i),
        .instr_ready_o  (instr_ready_o),
        .instr_i        (instr_i),
        .rs_i           (rs_i),
        .rs_valid_i     (rs_valid_i),
        .flush_i        (flush_i),
        .result_valid_o (result_valid_o),
        .result_data_o  (result_data_o),
        .result_rd_o    (result_rd_o),
        .result_we_o    (result_we_o),
        .illegal_o      (illegal_o),
        .timeout_o      (timeout_o),
        .cvxif_req_o    (req),
        .cvxif_resp_i   (resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every result pulse is matched against the oldest scoreboard entry.
    always @(negedge clk) begin
        if (!rst) begin
            if (result_valid_o) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", 64'd1, 64'd0);
                end else begin
                    m_e = sb.pop_front();
                    chk("res_data", 64'(result_data_o), 64'(m_e.data));
                    chk("res_rd", 64'(result_rd_o), 64'(m_e.rd));
                    chk("res_we", 64'(result_we_o), 64'(m_e.we));
                    chk("res_illegal", 64'(illegal_o), 64'(m_e.illegal));
                    chk("res_timeout", 64'(timeout_o), 64'(m_e.timeout));
                end
            end else begin
                chk("idle_outputs_zero",
                    64'({result_data_o, result_rd_o, result_we_o, illegal_o, timeout_o}), 64'd0);
            end
        end
    end

    task automatic check_issue(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b);
        chk("issue_valid", 64'(req.x_issue_valid), 64'd1);
        chk("issue_instr", 64'(req.x_issue_req.instr), 64'(instr));
        chk("issue_id", 64'(req.x_issue_req.id), 64'(exp_id));
        chk("issue_rs1", 64'(req.x_issue_req.rs[0]), 64'(a));
        chk("issue_rs2", 64'(req.x_issue_req.rs[1]), 64'(b));
        chk("issue_rs_valid", 64'(req.x_issue_req.rs_valid), 64'd3);
        chk("issue_mode", 64'(req.x_issue_req.mode), 64'd3);
    endtask

    // Drives one instruction through the DUT, also acting as the coprocessor. Starts and ends at a negedge.
    task automatic send(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b,
                        input bit accept, input bit wb, input int ready_dly, input bit flush_issue,
                        input int res_dly, input logic [31:0] res_data, input bit res_we,
                        input bit flush_wait, input bit silent, input bit bad_id);
        exp_t e;
        int n;
        logic [X_ID_WIDTH-1:0] id_now;
        logic [4:0] rd;
        rd = instr[11:7];
        n = 0;
        while (!instr_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("instr_ready", 64'(instr_ready_o), 64'd1);
        instr_valid_i = 1'b1;
        instr_i       = instr;
        rs_i          = {32'd0, b, a};
        rs_valid_i    = 3'b011;
        @(posedge clk); #1;
        instr_valid_i = 1'b0;
        instr_i       = '1;
        rs_i          = '1;
        rs_valid_i    = '0;
        if (flush_issue) flush_i = 1'b1;
        for (int k = 0; k < ready_dly; k++) begin
            @(negedge clk);
            check_issue(instr, a, b);
            @(posedge clk); #1;
            flush_i = 1'b0;
        end
        resp.x_issue_ready            = 1'b1;
        resp.x_issue_resp.accept      = accept;
        resp.x_issue_resp.writeback   = wb;
        @(negedge clk);
        check_issue(instr, a, b);
        @(posedge clk); #1;
        resp.x_issue_ready = 1'b0;
        resp.x_issue_resp  = '0;
        flush_i            = 1'b0;
        id_now             = exp_id;
        exp_id             = exp_id + X_ID_WIDTH'(1);
        if (!accept) begin
            e = '{data: 32'd0, rd: rd, we: 1'b0, illegal: 1'b1, timeout: 1'b0};
            sb.push_back(e);
            @(negedge clk);
            chk("illegal_no_commit", 64'(req.x_commit_valid), 64'd0);
            chk("illegal_pulse", 64'(result_valid_o), 64'd1);
            return;
        end
        @(negedge clk);
        chk("commit_valid", 64'(req.x_commit_valid), 64'd1);
        chk("commit_id", 64'(req.x_commit.id), 64'(id_now));
        chk("commit_kill", 64'(req.x_commit.commit_kill), 64'(flush_issue));
        @(posedge clk); #1;
        if (flush_issue) begin
            @(negedge clk);
            chk("kill_commit_once", 64'(req.x_commit_valid), 64'd0);
            chk("kill_no_result_ready", 64'(req.x_result_ready), 64'd0);
            chk("kill_idle", 64'(instr_ready_o), 64'd1);
            return;
        end
        if (flush_wait) flush_i = 1'b1;
        if (silent) begin
            e = '{data: 32'd0, rd: rd, we: 1'b0, illegal: 1'b0, timeout: 1'b1};
            sb.push_back(e);
            n = 0;
            @(negedge clk);
            chk("wait_result_ready", 64'(req.x_result_ready), 64'd1);
            while (!result_valid_o && n < 40) begin
                @(negedge clk);
                n++;
            end
            chk("timeout_latency", 64'(n), 64'd8);
            return;
        end
        for (int k = 0; k < res_dly; k++) begin
            @(negedge clk);
            chk("result_ready", 64'(req.x_result_ready), 64'd1);
            @(posedge clk); #1;
            flush_i = 1'b0;
        end
        if (bad_id) begin
            resp.x_result_valid = 1'b1;
            resp.x_result       = '0;
            resp.x_result.id    = id_now + X_ID_WIDTH'(1);
            resp.x_result.data  = 32'd999;
            resp.x_result.we    = 1'b1;
            @(posedge clk); #1;
        end
        resp.x_result_valid = 1'b1;
        resp.x_result       = '0;
        resp.x_result.id    = id_now;
        resp.x_result.data  = res_data;
        resp.x_result.rd    = rd;
        resp.x_result.we    = res_we;
        if (!flush_wait) begin
            e = '{data: res_data, rd: rd, we: res_we & wb, illegal: 1'b0, timeout: 1'b0};
            sb.push_back(e);
        end
        @(negedge clk);
        chk("result_ready_hs", 64'(req.x_result_ready), 64'd1);
        @(posedge clk); #1;
        resp.x_result_valid = 1'b0;
        resp.x_result       = '0;
        flush_i             = 1'b0;
        @(negedge clk);
        chk("result_pulse", 64'(result_valid_o), 64'(!flush_wait));
        chk("back_to_idle", 64'(instr_ready_o), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        instr_valid_i = 1'b0;
        instr_i       = '0;
        rs_i          = '0;
        rs_valid_i    = '0;
        flush_i       = 1'b0;
        resp          = '0;
        exp_id        = '0;

        repeat (2) @(negedge clk);
        chk("rst_instr_ready", 64'(instr_ready_o), 64'd0);
        chk("rst_result_valid", 64'(result_valid_o), 64'd0);
        chk("rst_issue_valid", 64'(req.x_issue_valid), 64'd0);
        chk("rst_commit_valid", 64'(req.x_commit_valid), 64'd0);
        chk("rst_result_ready", 64'(req.x_result_ready), 64'd0);
        chk("tieoff_mem_ready", 64'(req.x_mem_ready), 64'd0);
        chk("tieoff_compressed", 64'(req.x_compressed_valid), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 64'(instr_ready_o), 64'd1);

        // Custom add: 5+7=12, rd=3, id 0 then 1.
        send(32'h0020_818B, 32'd5, 32'd7, 1, 1, 0, 0, 0, 32'd12, 1, 0, 0, 0);
        send(32'h0020_828B, 32'd100, 32'd23, 1, 1, 0, 0, 0, 32'd123, 1, 0, 0, 0);
        // Writeback not granted at issue: we must be masked.
        send(32'h0020_830B, 32'd1, 32'd2, 1, 0, 1, 0, 2, 32'd3, 1, 0, 0, 0);
        // Standard ADD rejected.
        send(32'h0020_81B3, 32'd1, 32'd1, 0, 0, 0, 0, 0, 32'd0, 0, 0, 0, 0);

        // Flush in IDLE: candidate not taken.
        instr_valid_i = 1'b1;
        instr_i       = 32'h0020_818B;
        flush_i       = 1'b1;
        @(posedge clk); #1;
        instr_valid_i = 1'b0;
        flush_i       = 1'b0;
        @(negedge clk);
        chk("idle_flush_not_taken", 64'(req.x_issue_valid), 64'd0);
        chk("idle_flush_ready", 64'(instr_ready_o), 64'd1);

        // Flush in ISSUE with ready low 3 cycles -> killed at commit.
        send(32'h0020_838B, 32'd9, 32'd9, 1, 1, 3, 1, 0, 32'd0, 0, 0, 0, 0);
        // Flush in WAIT, result after 4 cycles -> drained silently.
        send(32'h0020_840B, 32'd4, 32'd4, 1, 1, 0, 0, 4, 32'd8, 1, 1, 0, 0);
        send(32'h0020_848B, 32'd20, 32'd22, 1, 1, 0, 0, 0, 32'd42, 1, 0, 0, 0);
        // Silent coprocessor -> timeout 8 cycles after entering WAIT.
        send(32'h0020_850B, 32'd0, 32'd0, 1, 1, 0, 0, 0, 32'd0, 0, 0, 1, 0);
        // Mismatched id dropped before the real result.
        send(32'h0020_858B, 32'd30, 32'd3, 1, 1, 0, 0, 1, 32'd33, 1, 0, 0, 1);

        // Reset mid-operation.
        instr_valid_i = 1'b1;
        instr_i       = 32'h0020_818B;
        @(posedge clk); #1;
        instr_valid_i = 1'b0;
        @(negedge clk);
        chk("midrst_issuing", 64'(req.x_issue_valid), 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("midrst_issue_dropped", 64'(req.x_issue_valid), 64'd0);
        chk("midrst_ready_low", 64'(instr_ready_o), 64'd0);
        @(posedge clk); #1;
        rst    = 1'b0;
        exp_id = '0;
        @(negedge clk);
        chk("midrst_ready", 64'(instr_ready_o), 64'd1);

        // 2^X_ID_WIDTH+1 back-to-back instructions: ids wrap to 0.
        for (int i = 0; i < (1 << X_ID_WIDTH) + 1; i++) begin
            send({20'h00208, 5'(i + 1), 7'h0B}, 32'(i * 3), 32'd10, 1, 1, 0, 0, 0,
                 32'(i * 3 + 10), 1, 0, 0, 0);
        end
        chk("id_wrapped", 64'(exp_id), 64'd1);
        chk("id_req_wrapped", 64'(req.x_issue_req.id), 64'd1);

        repeat (3) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cvxif_offload_unit.md
# cvxif_offload_unit

Core-side initiator for the CoreV-X-Interface. It takes one custom instruction at a time from the core's issue stage and drives it onto `cvxif_req_o`. It then performs the commit handshake, collects the coprocessor result, and returns a writeback packet to the core. It is the counterpart of the example coprocessor and handles exactly one outstanding offloaded instruction; the compressed and memory sub-interfaces are tied off.

## Interface
- `TimeoutCycles`, default 1024: number of cycles in WAIT without a result before the unit aborts with an exception; minimum 2.
- `clk_i`  in  1  clock
- `rst_i`  in  1  reset, asynchronous, active-high
- `instr_valid_i`  in  1  core presents an offload candidate
- `instr_ready_o`  out  1  unit can take a candidate (IDLE only)
- `instr_i`  in  32  instruction word
- `rs_i`  in  3x32  rs1/rs2/rs3 operand values
- `rs_valid_i`  in  3  operand valid flags
- `flush_i`  in  1  core squashes the in-flight instruction
- `result_valid_o`  out  1  one-cycle writeback/exception pulse
- `result_data_o`  out  32  result value
- `result_rd_o`  out  5  destination register
- `result_we_o`  out  1  register write enable
- `illegal_o`  out  1  coprocessor rejected the instruction
- `timeout_o`  out  1  result never arrived
- `cvxif_req_o`  out  cvxif_req_t  request bundle to the coprocessor
- `cvxif_resp_i`  in  cvxif_resp_t  response bundle from the coprocessor

## Operation
- FSM states: IDLE, ISSUE, COMMIT, WAIT, DRAIN.
- IDLE:
  - `instr_ready_o`=1.
  - On `instr_valid_i`, latch the instruction, operands, flags and `rd` (`instr_i[11:7]`), then go to ISSUE.
- ISSUE:
  - `x_issue_valid`=1 with the latched request and `id`=`id_q`; the request is held stable until `x_issue_ready`.
  - On handshake, sample `x_issue_resp` in the same cycle and increment `id_q` (wraps modulo 2^X_ID_WIDTH).
  - `accept`=0: pulse `result_valid_o` with `illegal_o`=1 and `we`=0, then go to IDLE.
  - `accept`=1: store `writeback`, then go to COMMIT.
- COMMIT:
  - `x_commit_valid`=1 for exactly one cycle, with `x_commit.id` = issued id and `x_commit_kill` = `flush_i` or `flush_pend`.
  - Kill: go to IDLE; no result is expected.
  - No kill: go to WAIT and clear the timeout counter.
- WAIT:
  - `x_result_ready`=1.
  - On `x_result_valid` with matching `id`, pulse `result_valid_o` with `data`, `rd`, and `we` = `x_result.we & writeback_q`, then go to IDLE.
  - A result with a mismatched id is consumed and dropped.
  - `flush_i` in WAIT: go to DRAIN; a committed instruction cannot be killed.
- DRAIN: `x_result_ready`=1; the matching result is consumed with no core-side output, then go to IDLE.
- Timeout:
  - The counter increments every WAIT/DRAIN cycle.
  - At `TimeoutCycles`-1 without a result, WAIT pulses `result_valid_o` with `timeout_o`=1 and `we`=0, then goes to IDLE; DRAIN returns to IDLE silently.
- `flush_i` in ISSUE: sets `flush_pend`; the issue still completes, since `valid` must not drop before `ready`, and is killed in COMMIT.
- `flush_i` in IDLE: the candidate is not taken.
- Compressed and memory interfaces: valid/ready outputs are 0, data outputs are 0, `x_mem_ready`=0.
- Request fields: `mode`=M-mode constant.

## Timing
- Reset values: state IDLE; `id_q`=0; all valids and pulses 0; `instr_ready_o`=0 during reset, then 1; data outputs 0.
- Minimum latency: candidate taken at cycle N, issue at N+1 if ready, commit at N+2, result in the same cycle as `x_result_valid` (earliest N+3), `result_valid_o` registered at N+4.
- All `result_*` and `illegal_o`/`timeout_o` outputs are registered; they are high for one cycle and 0 otherwise.
- Reset mid-operation: return to IDLE immediately and drop all state; the coprocessor is reset by the same domain.

## Structure
- Package `cvxif_offload_pkg`: FSM state enum and the `OFFLOAD_MODE` constant.
- Bundles come from `cvxif_pkg` (`x_issue_req_t`, `x_commit_t`, `x_result_t`, `X_ID_WIDTH`).
- Single module, no sub-module.

## Test plan
- Add instruction, `rs`=5/7, coprocessor accepts and returns 12 with `we`=1 → one `result_valid_o` pulse, `data`=12, `rd`=`instr[11:7]`, `we`=1; `id` 0 then 1 on the next instruction.
- Non-custom opcode, `accept`=0 → `illegal_o`=1 pulse, no `x_commit_valid`, back to IDLE.
- `flush_i` during ISSUE with `x_issue_ready` low for 3 cycles → request stable, commit with kill=1, no result, IDLE.
- `flush_i` in WAIT, result after 4 cycles → result consumed, no `result_valid_o`, next instruction accepted.
- Coprocessor silent, `TimeoutCycles`=8 → `timeout_o` pulse exactly 8 cycles after entering WAIT.
- 2^X_ID_WIDTH+1 back-to-back instructions → id wraps to 0, every result matched.
